// File: rtl/chip_test_pkg.sv
// Shared definitions for the per-chip test engines: FSM states, sweep size and pin bit positions.
package chip_test_pkg;

  typedef logic [1:0] state_t;

  localparam state_t HALT = 2'd0;
  localparam state_t TEST = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int unsigned NUM_VECTORS = 256;

  // Bit positions of each NAND input pin within the drive vector.
  localparam int unsigned PIN1_BIT  = 0;
  localparam int unsigned PIN2_BIT  = 1;
  localparam int unsigned PIN4_BIT  = 2;
  localparam int unsigned PIN5_BIT  = 3;
  localparam int unsigned PIN9_BIT  = 4;
  localparam int unsigned PIN10_BIT = 5;
  localparam int unsigned PIN12_BIT = 6;
  localparam int unsigned PIN13_BIT = 7;

  // Bit positions of each gate output within the result/mask vector.
  localparam int unsigned PIN3_BIT  = 0;
  localparam int unsigned PIN6_BIT  = 1;
  localparam int unsigned PIN8_BIT  = 2;
  localparam int unsigned PIN11_BIT = 3;

  function automatic logic [3:0] nand_expect(input logic [7:0] vec);
    logic [3:0] res;
    for (int g = 0; g < 4; g++) begin
      res[g] = ~(vec[2*g] & vec[2*g+1]);
    end
    return res;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for asynchronous chip outputs, synchronous active-high reset.
module pin_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [Width-1:0] async_in,
  output logic [Width-1:0] sync_out
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/chip_7400.sv
// Exhaustive 256-vector test engine for a 7400 quad NAND; latches the first failing vector
// and which gates disagreed there.
module chip_7400
  import chip_test_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       DISP_RSLT,
  output logic       Done,
  output logic       RSLT,
  output logic [7:0] FAIL_VEC,
  output logic [3:0] FAIL_MASK,
  output logic       Pin1,
  output logic       Pin2,
  output logic       Pin4,
  output logic       Pin5,
  output logic       Pin9,
  output logic       Pin10,
  output logic       Pin12,
  output logic       Pin13,
  input  logic       Pin3,
  input  logic       Pin6,
  input  logic       Pin8,
  input  logic       Pin11
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);

  if (SETTLE_CYCLES < 3) begin : gen_settle_check
    $error("chip_7400: SETTLE_CYCLES must be at least 3");
  end

  state_t              state_q, state_d;
  logic [7:0]          vec_q, vec_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                pass_q, pass_d;
  logic [7:0]          fail_vec_q, fail_vec_d;
  logic [3:0]          fail_mask_q, fail_mask_d;
  logic [7:0]          pins_q, pins_d;
  logic [3:0]          raw_out;
  logic [3:0]          sync_out;
  logic [3:0]          mismatch;

  assign raw_out[PIN3_BIT]  = Pin3;
  assign raw_out[PIN6_BIT]  = Pin6;
  assign raw_out[PIN8_BIT]  = Pin8;
  assign raw_out[PIN11_BIT] = Pin11;

  pin_sync #(
    .Width (4)
  ) u_pin_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_in (raw_out),
    .sync_out (sync_out)
  );

  assign mismatch = sync_out ^ nand_expect(vec_q);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    fail_mask_d = fail_mask_q;
    case (state_q)
      HALT: begin
        if (Run) begin
          state_d     = TEST;
          vec_d       = '0;
          settle_d    = '0;
          pass_d      = 1'b1;
          fail_vec_d  = '0;
          fail_mask_d = '0;
        end
      end
      TEST: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          // Only the first failing vector is recorded.
          if ((mismatch != 4'b0000) && pass_q) begin
            pass_d      = 1'b0;
            fail_vec_d  = vec_q;
            fail_mask_d = mismatch;
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + 8'd1;
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      DONE: begin
        if (!Run && !DISP_RSLT) begin
          state_d = HALT;
        end
      end
      default: state_d = HALT;
    endcase
    pins_d = (state_d == TEST) ? vec_d : 8'h00;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= HALT;
      vec_q       <= '0;
      settle_q    <= '0;
      pass_q      <= 1'b0;
      fail_vec_q  <= '0;
      fail_mask_q <= '0;
      pins_q      <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      pass_q      <= pass_d;
      fail_vec_q  <= fail_vec_d;
      fail_mask_q <= fail_mask_d;
      pins_q      <= pins_d;
    end
  end

  assign Done      = (state_q == DONE);
  assign RSLT      = Done & pass_q;
  assign FAIL_VEC  = fail_vec_q;
  assign FAIL_MASK = fail_mask_q;

  assign Pin1  = pins_q[PIN1_BIT];
  assign Pin2  = pins_q[PIN2_BIT];
  assign Pin4  = pins_q[PIN4_BIT];
  assign Pin5  = pins_q[PIN5_BIT];
  assign Pin9  = pins_q[PIN9_BIT];
  assign Pin10 = pins_q[PIN10_BIT];
  assign Pin12 = pins_q[PIN12_BIT];
  assign Pin13 = pins_q[PIN13_BIT];

endmodule

// File: tb/tb_chip_7400.sv
// Directed bench for chip_7400 against a behavioural 7400 with selectable faults.
module tb_chip_7400;

  logic       Clk = 1'b0;
  logic       Reset, Run, DISP_RSLT;
  logic       Done, RSLT;
  logic [7:0] FAIL_VEC;
  logic [3:0] FAIL_MASK;
  logic       Pin1, Pin2, Pin4, Pin5, Pin9, Pin10, Pin12, Pin13;
  logic       Pin3, Pin6, Pin8, Pin11;
  logic [7:0] pins;
  logic       n0, n1, n2, n3;
  int         fault_mode;
  int         checks = 0;
  int         errors = 0;

  always #5 Clk = ~Clk;

  chip_7400 dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Run       (Run),
    .DISP_RSLT (DISP_RSLT),
    .Done      (Done),
    .RSLT      (RSLT),
    .FAIL_VEC  (FAIL_VEC),
    .FAIL_MASK (FAIL_MASK),
    .Pin1      (Pin1),
    .Pin2      (Pin2),
    .Pin4      (Pin4),
    .Pin5      (Pin5),
    .Pin9      (Pin9),
    .Pin10     (Pin10),
    .Pin12     (Pin12),
    .Pin13     (Pin13),
    .Pin3      (Pin3),
    .Pin6      (Pin6),
    .Pin8      (Pin8),
    .Pin11     (Pin11)
  );

  assign pins = {Pin13, Pin12, Pin10, Pin9, Pin5, Pin4, Pin2, Pin1};
  assign n0 = ~(Pin1 & Pin2);
  assign n1 = ~(Pin4 & Pin5);
  assign n2 = ~(Pin9 & Pin10);
  assign n3 = ~(Pin12 & Pin13);

  // 0: ideal, 1: Pin6 stuck-at-1, 2: 7408 AND, 3: Pin11 wired-AND with Pin3
  always_comb begin
    Pin3  = n0;
    Pin6  = n1;
    Pin8  = n2;
    Pin11 = n3;
    case (fault_mode)
      1: Pin6 = 1'b1;
      2: begin
        Pin3  = ~n0;
        Pin6  = ~n1;
        Pin8  = ~n2;
        Pin11 = ~n3;
      end
      3: begin
        Pin3  = n0 & n3;
        Pin11 = n0 & n3;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Run held for 5 cycles; n counts edges from the first one that sees Run high.
  task automatic run_sweep(output int n);
    n   = 0;
    Run = 1'b1;
    while (n < 2000 && Done !== 1'b1) begin
      tick();
      n++;
      if (n == 5) Run = 1'b0;
    end
    Run = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b0; DISP_RSLT = 1'b0; fault_mode = 0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (RSLT !== 1'b0) begin errors++; $display("FAIL reset_rslt got %b want 0", RSLT); end
    checks++; if (pins !== 8'h00) begin errors++; $display("FAIL reset_pins got %h want 00", pins); end
    checks++;
    if (FAIL_VEC !== 8'h00) begin errors++; $display("FAIL reset_fvec got %h want 00", FAIL_VEC); end
    checks++;
    if (FAIL_MASK !== 4'h0) begin errors++; $display("FAIL reset_fmask got %b want 0000", FAIL_MASK); end
  endtask

  task automatic test_ideal();
    int n;
    bit rslt_early;
    n = 0; rslt_early = 0;
    fault_mode = 0;
    Run = 1'b1;
    while (n < 2000 && Done !== 1'b1) begin
      tick();
      n++;
      if (n == 5) Run = 1'b0;
      if (RSLT !== 1'b0 && Done !== 1'b1) rslt_early = 1;
      if (n == 1) begin
        checks++;
        if (pins !== 8'h00) begin errors++; $display("FAIL start_pins got %h want 00", pins); end
      end
      if (n == 5) begin
        checks++;
        if (pins !== 8'h01) begin errors++; $display("FAIL vec1_pins got %h want 01", pins); end
      end
      if (n == 9) begin
        checks++;
        if (pins !== 8'h02) begin errors++; $display("FAIL vec2_pins got %h want 02", pins); end
      end
    end
    checks++; if (n !== 1025) begin errors++; $display("FAIL ideal_latency got %0d want 1025", n); end
    checks++; if (rslt_early) begin errors++; $display("FAIL rslt_before_done got 1 want 0"); end
    checks++; if (RSLT !== 1'b1) begin errors++; $display("FAIL ideal_rslt got %b want 1", RSLT); end
    checks++;
    if (FAIL_VEC !== 8'h00) begin errors++; $display("FAIL ideal_fvec got %h want 00", FAIL_VEC); end
    checks++;
    if (FAIL_MASK !== 4'h0) begin errors++; $display("FAIL ideal_fmask got %b want 0000", FAIL_MASK); end
    checks++; if (pins !== 8'h00) begin errors++; $display("FAIL done_pins got %h want 00", pins); end
    tick();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL ideal_exit got %b want 0", Done); end
  endtask

  task automatic test_faults();
    int n;
    int         mode_tab [3] = '{1, 2, 3};
    logic [7:0] vec_tab  [3] = '{8'h0C, 8'h00, 8'h03};
    logic [3:0] mask_tab [3] = '{4'b0010, 4'b1111, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      fault_mode = mode_tab[i];
      run_sweep(n);
      checks++;
      if (n !== 1025) begin errors++; $display("FAIL fault%0d_latency got %0d want 1025", i, n); end
      checks++;
      if (RSLT !== 1'b0) begin errors++; $display("FAIL fault%0d_rslt got %b want 0", i, RSLT); end
      checks++;
      if (FAIL_VEC !== vec_tab[i]) begin
        errors++; $display("FAIL fault%0d_fvec got %h want %h", i, FAIL_VEC, vec_tab[i]);
      end
      checks++;
      if (FAIL_MASK !== mask_tab[i]) begin
        errors++; $display("FAIL fault%0d_fmask got %b want %b", i, FAIL_MASK, mask_tab[i]);
      end
      tick();
    end
    fault_mode = 0;
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    fault_mode = 0;
    Run = 1'b1;
    while (n < 401) begin
      tick();
      n++;
      if (n == 5) Run = 1'b0;
    end
    checks++; if (pins !== 8'h64) begin errors++; $display("FAIL vec100_pins got %h want 64", pins); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (pins !== 8'h00) begin errors++; $display("FAIL midrst_pins got %h want 00", pins); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", Done); end
    repeat (5) tick();
    checks++; if (pins !== 8'h00) begin errors++; $display("FAIL midrst_idle got %h want 00", pins); end
    run_sweep(n);
    checks++; if (n !== 1025) begin errors++; $display("FAIL rerun_latency got %0d want 1025", n); end
    checks++; if (RSLT !== 1'b1) begin errors++; $display("FAIL rerun_rslt got %b want 1", RSLT); end
    tick();
  endtask

  task automatic test_done_hold();
    int n;
    int bad;
    n = 0; bad = 0;
    Run = 1'b1;
    while (n < 2000 && Done !== 1'b1) begin
      tick();
      n++;
    end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL hold_reach got %b want 1", Done); end
    repeat (50) begin
      tick();
      if (Done !== 1'b1 || RSLT !== 1'b1 || pins !== 8'h00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_run got %0d bad want 0", bad); end
    Run = 1'b0; DISP_RSLT = 1'b1;
    repeat (5) tick();
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL hold_disp got %b want 1", Done); end
    DISP_RSLT = 1'b0;
    tick();
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL hold_exit got %b want 0", Done); end
    checks++; if (RSLT !== 1'b0) begin errors++; $display("FAIL hold_rslt got %b want 0", RSLT); end
    bad = 0;
    repeat (8) begin
      tick();
      if (Done !== 1'b0 || pins !== 8'h00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL no_retrigger got %0d bad want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_faults();
    test_mid_reset();
    test_done_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
